// File: rtl/llr_load_sequencer.sv
// -----------------------------------------------------------------------------
// llr_load_sequencer
//
// Purpose:
//   Streams channel LLRs into the PE grid of an LDPC decoder, one frame at a
//   time. Word index i of a frame (0 .. L*K*K-1) is written to PE i/L at
//   address i%L. Each frame is preceded by a one-cycle decoder reset pulse.
//   When the whole frame is loaded, the sequencer waits for the decoder to
//   acknowledge it before starting the next one.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-high reset
//   llr_in         in   [IN_WIDTH]  channel LLR, two's complement
//   llr_valid      in   llr_in valid
//   llr_ready      out  sequencer accepts llr_in this cycle
//   dec_ack        in   one-cycle pulse, decoder consumed the loaded frame
//   ext_reset_out  out  one-cycle decoder frame-reset pulse
//   pe_select      out  [K*K] one-hot PE write strobe (registered)
//   load_add       out  [ADDR_WIDTH] PE memory write address (registered)
//   int_out        out  [MESSAGE_WIDTH] intrinsic word to decoder (registered)
//   frame_loaded   out  level, frame fully written and awaiting dec_ack
//   frame_count    out  [8] frames acknowledged, wraps 255->0
//
// Configuration:
//   LLR_SATURATE_EN  defined   : llr_in is clamped to +/-(2^(MESSAGE_WIDTH-1)-1)
//                    undefined : int_out is llr_in[MESSAGE_WIDTH-1:0]
// -----------------------------------------------------------------------------
module llr_load_sequencer #(
    parameter int L             = 32,
    parameter int K             = 6,
    parameter int ADDR_WIDTH    = 5,
    parameter int MESSAGE_WIDTH = 5,
    parameter int IN_WIDTH      = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [IN_WIDTH-1:0]      llr_in,
    input  logic                     llr_valid,
    output logic                     llr_ready,
    input  logic                     dec_ack,
    output logic                     ext_reset_out,
    output logic [K*K-1:0]           pe_select,
    output logic [ADDR_WIDTH-1:0]    load_add,
    output logic [MESSAGE_WIDTH-1:0] int_out,
    output logic                     frame_loaded,
    output logic [7:0]               frame_count
);

    localparam int NUM_PE = K * K;
    localparam int PE_W   = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        LOAD,
        WAIT_ACK
    } state_t;

    state_t                   state_reg, state_next;
    logic [PE_W-1:0]          pe_cnt_reg, pe_cnt_next;
    logic [ADDR_WIDTH-1:0]    addr_cnt_reg, addr_cnt_next;
    logic [7:0]               frame_count_reg, frame_count_next;

    logic [NUM_PE-1:0]        pe_select_reg;
    logic [ADDR_WIDTH-1:0]    load_add_reg;
    logic [MESSAGE_WIDTH-1:0] int_out_reg;

    logic                     transfer;
    logic                     last_addr;
    logic                     last_pe;
    logic [NUM_PE-1:0]        pe_onehot;
    logic [MESSAGE_WIDTH-1:0] conv_word;

    // llr_valid is only honoured while loading; everywhere else it is ignored.
    assign transfer  = (state_reg == LOAD) && llr_valid;
    assign last_addr = (addr_cnt_reg == ADDR_WIDTH'(L - 1));
    assign last_pe   = (pe_cnt_reg == PE_W'(NUM_PE - 1));

    // One-hot decode of the PE counter. The counter never exceeds NUM_PE-1,
    // so at most one strobe bit can ever be set.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PE; gi++) begin : g_pe_decode
            assign pe_onehot[gi] = (pe_cnt_reg == PE_W'(gi));
        end
    endgenerate

`ifdef LLR_SATURATE_EN
    // Symmetric clamp: the most negative message code is never produced so
    // that the decoder's magnitude arithmetic cannot overflow on negation.
    localparam logic signed [IN_WIDTH-1:0] SAT_MAX =
        IN_WIDTH'((1 << (MESSAGE_WIDTH - 1)) - 1);
    localparam logic signed [IN_WIDTH-1:0] SAT_MIN = -SAT_MAX;

    logic signed [IN_WIDTH-1:0] llr_signed;
    logic signed [IN_WIDTH-1:0] llr_clamped;

    assign llr_signed = $signed(llr_in);

    always_comb begin
        llr_clamped = llr_signed;
        if (llr_signed > SAT_MAX) begin
            llr_clamped = SAT_MAX;
        end else if (llr_signed < SAT_MIN) begin
            llr_clamped = SAT_MIN;
        end
    end

    assign conv_word = llr_clamped[MESSAGE_WIDTH-1:0];
`else
    // Plain truncation; the upper input bits are intentionally dropped.
    logic unused_llr_msbs;
    assign unused_llr_msbs = ^llr_in;
    assign conv_word       = llr_in[MESSAGE_WIDTH-1:0];
`endif

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            pe_cnt_reg      <= '0;
            addr_cnt_reg    <= '0;
            frame_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            pe_cnt_reg      <= pe_cnt_next;
            addr_cnt_reg    <= addr_cnt_next;
            frame_count_reg <= frame_count_next;
        end
    end

    // Next-state, counter update and state-decoded outputs.
    always_comb begin
        state_next       = state_reg;
        pe_cnt_next      = pe_cnt_reg;
        addr_cnt_next    = addr_cnt_reg;
        frame_count_next = frame_count_reg;
        llr_ready        = 1'b0;
        ext_reset_out    = 1'b0;
        frame_loaded     = 1'b0;

        case (state_reg)
            IDLE: begin
                state_next = CLEAR;
            end
            CLEAR: begin
                ext_reset_out = 1'b1;
                state_next    = LOAD;
            end
            LOAD: begin
                llr_ready = 1'b1;
                if (transfer) begin
                    if (last_addr) begin
                        addr_cnt_next = '0;
                        if (last_pe) begin
                            // Final word of the frame: counters rewind so the
                            // next frame starts at index 0.
                            pe_cnt_next = '0;
                            state_next  = WAIT_ACK;
                        end else begin
                            pe_cnt_next = pe_cnt_reg + 1'b1;
                        end
                    end else begin
                        addr_cnt_next = addr_cnt_reg + 1'b1;
                    end
                end
            end
            WAIT_ACK: begin
                frame_loaded = 1'b1;
                if (dec_ack) begin
                    frame_count_next = frame_count_reg + 8'd1;
                    state_next       = CLEAR;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Write-port registers: one cycle of latency after the accepting edge.
    // The strobe is a single-cycle pulse; address and data hold between writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pe_select_reg <= '0;
            load_add_reg  <= '0;
            int_out_reg   <= '0;
        end else begin
            pe_select_reg <= transfer ? pe_onehot : '0;
            if (transfer) begin
                load_add_reg <= addr_cnt_reg;
                int_out_reg  <= conv_word;
            end
        end
    end

    assign pe_select   = pe_select_reg;
    assign load_add    = load_add_reg;
    assign int_out     = int_out_reg;
    assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_llr_load_sequencer.sv
// -----------------------------------------------------------------------------
// tb_llr_load_sequencer
//
// Self-checking bench for llr_load_sequencer. A frame-level reference model
// tracks the phase of the sequencer, the index of the next word in the frame
// and the acknowledged-frame count; expected write strobes are derived
// directly from index arithmetic (PE = i/L, address = i%L).
// -----------------------------------------------------------------------------
module tb_llr_load_sequencer;

    localparam int L      = 32;
    localparam int K      = 6;
    localparam int AW     = 5;
    localparam int MW     = 5;
    localparam int IW     = 6;
    localparam int NPE    = K * K;
    localparam int FRAME  = L * NPE;

    localparam int PH_IDLE  = 0;
    localparam int PH_CLEAR = 1;
    localparam int PH_LOAD  = 2;
    localparam int PH_WAIT  = 3;

    logic           clk;
    logic           reset;
    logic [IW-1:0]  llr_in;
    logic           llr_valid;
    logic           llr_ready;
    logic           dec_ack;
    logic           ext_reset_out;
    logic [NPE-1:0] pe_select;
    logic [AW-1:0]  load_add;
    logic [MW-1:0]  int_out;
    logic           frame_loaded;
    logic [7:0]     frame_count;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int             m_phase;
    int             m_idx;
    int             m_frames;
    int             m_last;
    logic [NPE-1:0] exp_pe;
    logic [AW-1:0]  exp_add;
    logic [MW-1:0]  exp_int;
    int             dut_strobes;

    llr_load_sequencer #(
        .L(L), .K(K), .ADDR_WIDTH(AW), .MESSAGE_WIDTH(MW), .IN_WIDTH(IW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .llr_in(llr_in),
        .llr_valid(llr_valid),
        .llr_ready(llr_ready),
        .dec_ack(dec_ack),
        .ext_reset_out(ext_reset_out),
        .pe_select(pe_select),
        .load_add(load_add),
        .int_out(int_out),
        .frame_loaded(frame_loaded),
        .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Intrinsic word the decoder should see for a given channel LLR.
    function automatic logic [MW-1:0] ref_conv(input logic [IW-1:0] d);
        int v;
        v = int'($signed(d));
`ifdef LLR_SATURATE_EN
        if (v > 15)  v = 15;
        if (v < -15) v = -15;
`endif
        return MW'(v);
    endfunction

    task automatic model_reset();
        m_phase  = PH_IDLE;
        m_idx    = 0;
        m_frames = 0;
        m_last   = -1;
        exp_pe   = '0;
        exp_add  = '0;
        exp_int  = '0;
    endtask

    // Drive one cycle of inputs, advance one clock, update the model.
    task automatic tick(input logic v, input logic [IW-1:0] d, input logic ack);
        bit xfer;
        int old_phase;
        llr_valid = v;
        llr_in    = d;
        dec_ack   = ack;
        xfer      = (m_phase == PH_LOAD) && v;
        old_phase = m_phase;
        @(posedge clk);
        #1;
        exp_pe = '0;
        m_last = -1;
        if (xfer) begin
            exp_pe[m_idx / L] = 1'b1;
            exp_add = AW'(m_idx % L);
            exp_int = ref_conv(d);
            m_last  = m_idx;
            m_idx++;
        end
        case (old_phase)
            PH_IDLE:  m_phase = PH_CLEAR;
            PH_CLEAR: m_phase = PH_LOAD;
            PH_LOAD: begin
                if (m_idx == FRAME) begin
                    m_idx   = 0;
                    m_phase = PH_WAIT;
                end
            end
            default: begin
                if (ack) begin
                    m_frames = (m_frames + 1) % 256;
                    m_phase  = PH_CLEAR;
                end
            end
        endcase
        if (pe_select !== '0) dut_strobes++;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        llr_valid = 1'b0;
        llr_in    = '0;
        dec_ack   = 1'b0;
        model_reset();
        #2;
        checks++; if (pe_select !== '0) begin failures++; $display("FAIL reset_pe_select got=%h exp=0", pe_select); end
        checks++; if (load_add !== '0) begin failures++; $display("FAIL reset_load_add got=%0d exp=0", load_add); end
        checks++; if (int_out !== '0) begin failures++; $display("FAIL reset_int_out got=%h exp=0", int_out); end
        checks++; if (llr_ready !== 1'b0) begin failures++; $display("FAIL reset_llr_ready got=%b exp=0", llr_ready); end
        checks++; if (ext_reset_out !== 1'b0) begin failures++; $display("FAIL reset_ext_reset got=%b exp=0", ext_reset_out); end
        checks++; if (frame_loaded !== 1'b0) begin failures++; $display("FAIL reset_frame_loaded got=%b exp=0", frame_loaded); end
        checks++; if (frame_count !== 8'd0) begin failures++; $display("FAIL reset_frame_count got=%0d exp=0", frame_count); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        $display("reset: released, outputs idle");
    endtask

    task automatic test_full_frame();
        int cyc;
        tick(1'b1, 6'd0, 1'b0);
        checks++; if (ext_reset_out !== 1'b1) begin failures++; $display("FAIL clear_pulse got=%b exp=1", ext_reset_out); end
        checks++; if (llr_ready !== 1'b0) begin failures++; $display("FAIL clear_ready got=%b exp=0", llr_ready); end
        dut_strobes = 0;
        cyc = 0;
        while (m_phase != PH_WAIT && cyc < 2000) begin
            tick(1'b1, IW'($urandom), 1'b0);
            cyc++;
            checks++; if (pe_select !== exp_pe) begin failures++; $display("FAIL full_pe_select idx=%0d got=%h exp=%h", m_last, pe_select, exp_pe); end
            checks++; if (load_add !== exp_add) begin failures++; $display("FAIL full_load_add idx=%0d got=%0d exp=%0d", m_last, load_add, exp_add); end
            checks++; if (int_out !== exp_int) begin failures++; $display("FAIL full_int_out idx=%0d got=%h exp=%h", m_last, int_out, exp_int); end
            checks++; if (llr_ready !== (m_phase == PH_LOAD)) begin failures++; $display("FAIL full_llr_ready got=%b exp=%b", llr_ready, m_phase == PH_LOAD); end
            checks++; if (ext_reset_out !== 1'b0) begin failures++; $display("FAIL full_ext_reset got=%b exp=0", ext_reset_out); end
            checks++; if (frame_loaded !== (m_phase == PH_WAIT)) begin failures++; $display("FAIL full_frame_loaded got=%b exp=%b", frame_loaded, m_phase == PH_WAIT); end
            if (m_last == 0) begin
                checks++; if (pe_select !== 36'd1 || load_add !== 5'd0) begin failures++; $display("FAIL idx0_write got pe=%h add=%0d exp pe=1 add=0", pe_select, load_add); end
            end
            if (m_last == 33) begin
                checks++; if (pe_select !== 36'd2 || load_add !== 5'd1) begin failures++; $display("FAIL idx33_write got pe=%h add=%0d exp pe=2 add=1", pe_select, load_add); end
            end
            if (m_last == FRAME - 1) begin
                checks++; if (pe_select !== (36'd1 << 35) || load_add !== 5'd31) begin failures++; $display("FAIL idx1151_write got pe=%h add=%0d exp pe=800000000 add=31", pe_select, load_add); end
            end
        end
        checks++; if (m_phase != PH_WAIT) begin failures++; $display("FAIL full_timeout got cycles=%0d exp frame complete", cyc); end
        checks++; if (dut_strobes != FRAME) begin failures++; $display("FAIL full_strobe_count got=%0d exp=%0d", dut_strobes, FRAME); end
        $display("full_frame: %0d strobes in %0d cycles", dut_strobes, cyc);
    endtask

    task automatic test_wait_ack();
        for (int i = 0; i < 10; i++) begin
            tick(1'($urandom), IW'($urandom), 1'b0);
            checks++; if (frame_loaded !== 1'b1) begin failures++; $display("FAIL wait_frame_loaded cyc=%0d got=%b exp=1", i, frame_loaded); end
            checks++; if (llr_ready !== 1'b0) begin failures++; $display("FAIL wait_llr_ready cyc=%0d got=%b exp=0", i, llr_ready); end
            checks++; if (pe_select !== '0) begin failures++; $display("FAIL wait_pe_select cyc=%0d got=%h exp=0", i, pe_select); end
            checks++; if (frame_count !== 8'd0) begin failures++; $display("FAIL wait_frame_count cyc=%0d got=%0d exp=0", i, frame_count); end
        end
        tick(1'b1, 6'd5, 1'b1);
        checks++; if (frame_count !== 8'd1) begin failures++; $display("FAIL ack_frame_count got=%0d exp=1", frame_count); end
        checks++; if (ext_reset_out !== 1'b1) begin failures++; $display("FAIL ack_ext_reset got=%b exp=1", ext_reset_out); end
        checks++; if (frame_loaded !== 1'b0) begin failures++; $display("FAIL ack_frame_loaded got=%b exp=0", frame_loaded); end
        $display("wait_ack: frame_count=%0d after ack", frame_count);
    endtask

    task automatic test_random_frame();
        int cyc;
        dut_strobes = 0;
        cyc = 0;
        while (m_phase != PH_WAIT && cyc < 8000) begin
            // Stray dec_ack pulses during LOAD must be ignored.
            tick(1'($urandom_range(0, 2) != 0), IW'($urandom), 1'($urandom_range(0, 7) == 0));
            cyc++;
            checks++; if (pe_select !== exp_pe) begin failures++; $display("FAIL rand_pe_select idx=%0d got=%h exp=%h", m_last, pe_select, exp_pe); end
            checks++; if (load_add !== exp_add) begin failures++; $display("FAIL rand_load_add idx=%0d got=%0d exp=%0d", m_last, load_add, exp_add); end
            checks++; if (int_out !== exp_int) begin failures++; $display("FAIL rand_int_out idx=%0d got=%h exp=%h", m_last, int_out, exp_int); end
            checks++; if (llr_ready !== (m_phase == PH_LOAD)) begin failures++; $display("FAIL rand_llr_ready got=%b exp=%b", llr_ready, m_phase == PH_LOAD); end
            checks++; if (frame_count !== 8'(m_frames)) begin failures++; $display("FAIL rand_frame_count got=%0d exp=%0d", frame_count, m_frames); end
            checks++; if ($countones(pe_select) > 1) begin failures++; $display("FAIL rand_onehot got=%h exp=at most one bit", pe_select); end
        end
        checks++; if (m_phase != PH_WAIT) begin failures++; $display("FAIL rand_timeout got cycles=%0d exp frame complete", cyc); end
        checks++; if (dut_strobes != FRAME) begin failures++; $display("FAIL rand_strobe_count got=%0d exp=%0d", dut_strobes, FRAME); end
        tick(1'b0, 6'd0, 1'b1);
        checks++; if (frame_count !== 8'd2) begin failures++; $display("FAIL rand_ack_count got=%0d exp=2", frame_count); end
        $display("random_frame: %0d strobes in %0d cycles", dut_strobes, cyc);
    endtask

    task automatic test_saturation();
        logic [IW-1:0] vals [3];
        logic [MW-1:0] want [3];
        vals[0] = 6'd31;
        vals[1] = 6'b100000;
        vals[2] = 6'b111001;
`ifdef LLR_SATURATE_EN
        want[0] = 5'b01111;
        want[1] = 5'b10001;
        want[2] = 5'b11001;
`else
        want[0] = 5'b11111;
        want[1] = 5'b00000;
        want[2] = 5'b11001;
`endif
        tick(1'b1, 6'd0, 1'b0);
        checks++; if (llr_ready !== 1'b1) begin failures++; $display("FAIL sat_ready got=%b exp=1", llr_ready); end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, vals[i], 1'b0);
            checks++; if (int_out !== want[i]) begin failures++; $display("FAIL sat_int_out in=%h got=%b exp=%b", vals[i], int_out, want[i]); end
            checks++; if (load_add !== 5'(i)) begin failures++; $display("FAIL sat_load_add got=%0d exp=%0d", load_add, i); end
            $display("saturation: llr_in=%h int_out=%b", vals[i], int_out);
        end
    endtask

    task automatic test_reset_mid_load();
        int cyc;
        cyc = 0;
        while (m_idx < 500 && cyc < 2000) begin
            tick(1'b1, IW'($urandom), 1'b0);
            cyc++;
        end
        checks++; if (m_idx != 500) begin failures++; $display("FAIL midload_reach got idx=%0d exp=500", m_idx); end
        reset = 1'b1;
        model_reset();
        #1;
        checks++; if (pe_select !== '0) begin failures++; $display("FAIL midload_pe_select got=%h exp=0", pe_select); end
        checks++; if (load_add !== '0) begin failures++; $display("FAIL midload_load_add got=%0d exp=0", load_add); end
        checks++; if (int_out !== '0) begin failures++; $display("FAIL midload_int_out got=%h exp=0", int_out); end
        checks++; if (llr_ready !== 1'b0) begin failures++; $display("FAIL midload_llr_ready got=%b exp=0", llr_ready); end
        checks++; if (frame_count !== 8'd0) begin failures++; $display("FAIL midload_frame_count got=%0d exp=0", frame_count); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(1'b1, 6'd9, 1'b0);
        checks++; if (ext_reset_out !== 1'b1) begin failures++; $display("FAIL midload_clear got=%b exp=1", ext_reset_out); end
        tick(1'b1, 6'd9, 1'b0);
        checks++; if (llr_ready !== 1'b1) begin failures++; $display("FAIL midload_load got=%b exp=1", llr_ready); end
        tick(1'b1, 6'd9, 1'b0);
        checks++; if (pe_select !== 36'd1 || load_add !== 5'd0) begin failures++; $display("FAIL midload_restart got pe=%h add=%0d exp pe=1 add=0", pe_select, load_add); end
        checks++; if (int_out !== exp_int) begin failures++; $display("FAIL midload_int_out2 got=%h exp=%h", int_out, exp_int); end
        $display("reset_mid_load: restarted at index 0, frame_count=%0d", frame_count);
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_wait_ack();
        test_random_frame();
        test_saturation();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
